// File: rtl/fifo.sv
// fifo: single-clock FIFO with registered read data and full/empty flags; FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
//   clk, rst (async, active-high), write_en/read_en requests, data_in word,
//   full/empty status, data_out registered read word, [overflow/underflow sticky errors]
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] data_out
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] one = 1;
  localparam logic [ADDR_WIDTH:0] full_count = (ADDR_WIDTH+1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wptr, rptr, count;
  logic do_wr, do_rd;
  assign empty = count == '0;
  assign full = count == full_count;
  assign do_wr = write_en && !full;
  assign do_rd = read_en && !empty;
  always_ff @(posedge clk)
    if (do_wr) mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      data_out <= '0;
    end else begin
      if (do_wr) wptr <= wptr + one;
      if (do_rd) begin
        rptr <= rptr + one;
        data_out <= mem[rptr[ADDR_WIDTH-1:0]];
      end
      count <= (do_wr && !do_rd) ? count + one : (!do_wr && do_rd) ? count - one : count;
    end
`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= overflow || (write_en && full);
      underflow <= underflow || (read_en && empty);
    end
`endif
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed and random stimulus against a queue-based reference model
module tb_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 0, write_en = 0, read_en = 0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic full, empty;
  logic [DW-1:0] q[$];
  logic [DW-1:0] dout_m = '0;
  int checks = 0, errors = 0;
`ifdef FIFO_ERR_FLAGS_EN
  logic overflow, underflow;
  logic ov_m = 0, un_m = 0;
`endif
  fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .data_in(data_in),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow(overflow), .underflow(underflow),
`endif
    .full(full), .empty(empty), .data_out(data_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_state(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, ".data_out"}, 32'(data_out), 32'(dout_m));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, ".overflow"}, 32'(overflow), 32'(ov_m));
    check({tag, ".underflow"}, 32'(underflow), 32'(un_m));
`endif
  endtask
  task automatic model_reset();
    q.delete();
    dout_m = '0;
`ifdef FIFO_ERR_FLAGS_EN
    ov_m = 0;
    un_m = 0;
`endif
  endtask
  task automatic step(input string tag, input logic we, input logic re, input logic [DW-1:0] din);
    bit wr_ok, rd_ok;
    write_en = we;
    read_en = re;
    data_in = din;
    wr_ok = we && q.size() < DEPTH;
    rd_ok = re && q.size() > 0;
`ifdef FIFO_ERR_FLAGS_EN
    if (we && q.size() == DEPTH) ov_m = 1;
    if (re && q.size() == 0) un_m = 1;
`endif
    @(posedge clk);
    #1;
    if (rd_ok) dout_m = q.pop_front();
    if (wr_ok) q.push_back(din);
    write_en = 0;
    read_en = 0;
    check_state(tag);
  endtask
  initial begin
    write_en = 1'($urandom);
    read_en = 1'($urandom);
    data_in = DW'($urandom);
    #2 rst = 1;
    #1 model_reset();
    check_state("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 3; i++) step("reset_rd", 0, 1, DW'($urandom));
    for (int i = 1; i <= DEPTH; i++) step("fill", 1, 0, DW'(i));
    check("fill_full", 32'(full), 32'd1);
    step("fill_over", 1, 0, 8'hAA);
    for (int i = 0; i <= DEPTH; i++) step("drain", 0, 1, '0);
    check("drain_last", 32'(data_out), 32'h10);
    for (int i = 0; i < 10; i++) step("wrap_w10", 1, 0, DW'(8'h20 + i));
    for (int i = 0; i < 10; i++) step("wrap_r10", 0, 1, '0);
    for (int i = 0; i < 12; i++) step("wrap_w12", 1, 0, DW'(8'h40 + i));
    for (int i = 0; i < 12; i++) step("wrap_r12", 0, 1, '0);
    for (int i = 0; i < 5; i++) step("sim_pre", 1, 0, DW'(8'h60 + i));
    for (int i = 0; i < 8; i++) step("sim_rw", 1, 1, DW'(8'h70 + i));
    for (int i = 0; i < 5; i++) step("sim_post", 0, 1, '0);
    step("sim_empty", 1, 1, 8'h99);
    step("sim_empty_rd", 0, 1, '0);
    for (int i = 0; i < DEPTH; i++) step("sim_fill", 1, 0, DW'(8'h80 + i));
    step("sim_full", 1, 1, 8'hBB);
    check("sim_full_fell", 32'(full), 32'd0);
    for (int i = 0; i < DEPTH; i++) step("sim_drain", 0, 1, '0);
    for (int i = 0; i < 7; i++) step("mid_w", 1, 0, DW'($urandom));
    #3 rst = 1;
    #1 model_reset();
    check_state("mid_rst");
    #2 rst = 0;
    step("post_w", 1, 0, 8'h5A);
    step("post_r", 0, 1, '0);
    check("post_r_5a", 32'(data_out), 32'h5A);
    for (int i = 0; i < 2000; i++)
      step("rand", $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, DW'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo.md
# fifo

Synchronous single-clock first-in/first-out buffer, 8 bits wide and 16 entries deep by default. It decouples a byte producer from a byte consumer within one clock domain. It provides registered read data and full/empty status flags. Overflowing writes and underflowing reads are ignored, so the buffer contents are never corrupted.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 16, number of entries; must be a power of two ≥ 2.
- ADDR_WIDTH, log2(DEPTH) = 4, pointer index width (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- write_en  input  1  write request for the current cycle.
- read_en  input  1  read request for the current cycle.
- data_in  input  DATA_WIDTH  word to store when a write is accepted.
- full  output  1  high when DEPTH words are stored.
- empty  output  1  high when no words are stored.
- data_out  output  DATA_WIDTH  registered read data.

## Operation
- Storage: DEPTH × DATA_WIDTH register array. The array is not reset.
- Pointers: write pointer and read pointer, each ADDR_WIDTH+1 bits; the MSB is the wrap bit.
- Occupancy: count register, 0..DEPTH.
- Write acceptance:
  - Accepted iff write_en=1 and full=0.
  - mem[wptr] ← data_in, then wptr increments.
  - A write with full=1 is dropped; no state changes.
- Read acceptance:
  - Accepted iff read_en=1 and empty=0.
  - data_out ← mem[rptr], then rptr increments.
  - A read with empty=1 is dropped; data_out holds its value.
- Simultaneous requests:
  - Neither flag set: both are accepted and count is unchanged.
  - full=1: only the read is accepted.
  - empty=1: only the write is accepted. There is no fall-through; data_out does not change that cycle.
- Flags, derived from count (equivalently, from the pointers):
  - empty = (count==0).
  - full = (count==DEPTH).
- Wrap-around: pointers wrap modulo 2·DEPTH. Address bits index the array, so entry order is strict FIFO across any number of wraps.
- data_out holds the last word read until the next accepted read.

## Timing
- Reset (asynchronous assert, synchronous-clean release):
  - wptr=0, rptr=0, count=0.
  - empty=1, full=0, data_out=0.
- Reset asserted mid-operation discards all contents immediately; flags return to their reset values without waiting for a clock edge.
- Write latency:
  - Data written on edge N is readable with read_en sampled at edge N+1.
  - empty falls after edge N.
- Read latency: data_out is valid immediately after the edge at which the read is accepted, i.e. one cycle of latency from read_en.
- Flag timing:
  - full rises after the edge that accepts the DEPTH-th outstanding write.
  - full falls after the first accepted read.
  - Both flags are registered or pointer-derived with no combinational path from write_en/read_en.

## Configuration
- FIFO_ERR_FLAGS_EN defined: adds two output ports.
  - overflow (1 bit): sticky; set when write_en=1 while full=1.
  - underflow (1 bit): sticky; set when read_en=1 while empty=1.
  - Both reset to 0 and are cleared only by rst.
- FIFO_ERR_FLAGS_EN undefined: these ports and their logic are absent; dropped requests are silent.

## Test plan
- Reset: assert rst with random inputs → empty=1, full=0, data_out=0x00. Then read_en=1 for 3 cycles → data_out stays 0x00 and empty stays 1.
- Fill: write 0x01..0x10 on 16 consecutive cycles → full=1 after the 16th edge. A 17th write of 0xAA is dropped: full stays 1, and overflow=1 when FIFO_ERR_FLAGS_EN is defined.
- Drain: from full, read 16 cycles → data_out sequence 0x01..0x10 in order; empty=1 after the 16th read. A 17th read leaves data_out=0x10.
- Wrap: write 10, read 10, write 12, read 12 (distinct values) → all values emerge in order across the pointer wrap; flags correct at each boundary.
- Simultaneous read and write:
  - At count=5 for 8 cycles → count stays 5 and ordering is preserved.
  - While empty → only the write is taken; empty=0 next cycle.
  - While full → only the read is taken; full=0 next cycle.
- Mid-operation reset: after 7 writes, pulse rst between clock edges → empty=1 and full=0 immediately. A subsequent write of 0x5A followed by a read returns 0x5A.
